param_sync_fifo: RTL and testbench
==================================

// Module: param_sync_fifo
// PURPOSE
//  Parametrised single-clock FIFO, next generation of the verification-target FIFO.
//  Adds: arbitrary (non-power-of-2) depth, runtime-programmable almost-full/almost-empty thresholds,
//  read+write acceptance when full, synchronous flush, read-valid strobe, optional first-word-fall-through.
//  Sits between a producer and a consumer in the same clock domain as a rate-decoupling buffer.
// PARAMETERS
//  DATA_W  16  data word width, >=1
//  DEPTH    8  number of entries, >=2, need not be a power of 2
//  ADDR_W  $clog2(DEPTH)    localparam, pointer width
//  CNT_W   $clog2(DEPTH+1)  localparam, occupancy width
// PORTS
//  clk          in   1       single clock, all logic on rising edge
//  rst          in   1       asynchronous, active-high reset
//  clear        in   1       synchronous flush, priority over wr_en/rd_en
//  wr_en        in   1       write request
//  data_in      in   DATA_W  write data
//  rd_en        in   1       read request
//  af_thresh    in   CNT_W   almost-full threshold
//  ae_thresh    in   CNT_W   almost-empty threshold
//  data_out     out  DATA_W  read data
//  rd_valid     out  1       data_out carries a newly read word
//  wr_ack       out  1       previous-cycle write accepted
//  overflow     out  1       previous-cycle write rejected (full)
//  underflow    out  1       previous-cycle read rejected (empty)
//  full/empty   out  1       count==DEPTH / count==0, combinational
//  almostfull   out  1       count >= af_thresh, combinational
//  almostempty  out  1       count <= ae_thresh, combinational
//  count        out  CNT_W   current occupancy
// BEHAVIOUR
//  Reset (rst=1, async): wr_ptr=rd_ptr=count=0, data_out=0, rd_valid=wr_ack=overflow=underflow=0.
//   Resulting flags: empty=1, full=0.
//   Reset mid-operation discards contents; memory array is not cleared.
//  rd_acc = rd_en & ~empty. wr_acc = wr_en & (~full | rd_acc); a write to a full FIFO is accepted when a read is accepted in the same cycle.
//  Empty with wr_en&rd_en: write accepted, read rejected (underflow=1 next cycle), count+1.
//  count next = count + wr_acc - rd_acc; it never leaves the range 0..DEPTH.
//  Pointers advance by 1 on accept; the value DEPTH-1 wraps to 0. Pointers never hold the value DEPTH.
//  wr_ack/overflow/underflow: registered, asserted exactly the cycle after the event and cleared when the event does not repeat.
//   overflow = wr_en & ~wr_acc; underflow = rd_en & ~rd_acc.
//  Read latency 1: on rd_acc, data_out <= mem[rd_ptr] and rd_valid <= 1. Otherwise rd_valid <= 0 and data_out holds.
//  clear=1: pointers and count go to 0; wr_ack/overflow/underflow/rd_valid go to 0; data_out holds.
//   No write or read is performed in that cycle.
//  Thresholds are sampled combinationally and may change at any time. af_thresh=0 -> almostfull constantly 1.
//   ae_thresh>=DEPTH -> almostempty constantly 1.
// CONFIGURATION
//  FIFO_FWFT_EN defined: first-word-fall-through mode.
//   data_out = mem[rd_ptr] combinationally; rd_valid = ~empty combinationally.
//   rd_en acknowledges the head word, and the next word appears the following cycle.
//   Read latency 0. Reset/clear force rd_valid=0 via empty.
//  FIFO_FWFT_EN undefined: registered read as described above (latency 1).
//  All other behaviour is identical in both modes.
// STRUCTURE
//  Package fifo_pkg: default DATA_W/DEPTH constants; typedef fifo_flags_t (full, empty, almostfull, almostempty).
//  Sub-module fifo_wrap_ptr (#(DEPTH, ADDR_W); ports clk, rst, clear, inc, ptr) provides the modulo-DEPTH counter.
//   Instantiated twice, for the write and read pointers.
//  Memory: plain reg array [DEPTH-1:0], with no reset.
// TESTING  (DEPTH=5, DATA_W=16, af_thresh=4, ae_thresh=1 unless noted)
//  T1 Reset: assert rst mid-burst -> count=0, empty=1, all strobes=0, data_out=0 in the same cycle.
//  T2 Fill: write 0xA0..0xA4 over 5 cycles -> wr_ack 5 cycles, full=1, almostfull from count=4.
//   6th write -> overflow=1 next cycle, count stays 5.
//  T3 Wrap: fill 5, read 3, write 3 (wr_ptr wraps 4->0), read 5 -> data order preserved, last word 0xB2.
//   rd_valid=1 each cycle after a read, underflow=0.
//  T4 Full simultaneous: count=5, wr_en=rd_en=1 with 0xCC -> wr_ack=1, overflow=0, count=5.
//   0xCC later read in 5th position.
//  T5 Empty simultaneous: count=0, wr_en=rd_en=1 -> underflow=1, wr_ack=1, count=1.
//  T6 Clear: count=3, clear=1 with wr_en=1 -> count=0, empty=1, wr_ack=0, data_out unchanged.
//   Repeat T3 with FIFO_FWFT_EN: data_out=0xA0 while rd_en=0 after the first write.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and types for the parametrised single-clock FIFO.
// Default geometry lives here so the interface and the top agree on it.
package fifo_pkg;

    localparam int FIFO_DATA_W_DEF = 16;
    localparam int FIFO_DEPTH_DEF  = 8;

    // Occupancy-derived status flags, grouped so they travel together.
    typedef struct packed {
        logic full;
        logic empty;
        logic almostfull;
        logic almostempty;
    } fifo_flags_t;

endpackage : fifo_pkg

// File: rtl/param_sync_fifo_if.sv
// Producer/consumer-facing bundle of the parametrised FIFO.
// The slave modport is the FIFO itself; the master modport is the user side.
interface param_sync_fifo_if
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              clear;
    logic              wr_en;
    logic [DATA_W-1:0] data_in;
    logic              rd_en;
    logic [CNT_W-1:0]  af_thresh;
    logic [CNT_W-1:0]  ae_thresh;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              wr_ack;
    logic              overflow;
    logic              underflow;
    logic              full;
    logic              empty;
    logic              almostfull;
    logic              almostempty;
    logic [CNT_W-1:0]  count;

    modport master (
        output clear, wr_en, data_in, rd_en, af_thresh, ae_thresh,
        input  data_out, rd_valid, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty, count
    );

    modport slave (
        input  clear, wr_en, data_in, rd_en, af_thresh, ae_thresh,
        output data_out, rd_valid, wr_ack, overflow, underflow,
               full, empty, almostfull, almostempty, count
    );

endinterface : param_sync_fifo_if

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer: advances by one on inc and wraps DEPTH-1 -> 0,
// so non-power-of-2 depths never produce an out-of-range address.
module fifo_wrap_ptr #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              inc,
    output logic [ADDR_W-1:0] ptr
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] r_ptr;

    // Flush has priority over advancing; wrap explicitly at the last entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (clear) begin
            r_ptr <= '0;
        end else if (inc) begin
            r_ptr <= (r_ptr == LAST) ? '0 : r_ptr + ADDR_W'(1);
        end
    end

    assign ptr = r_ptr;

endmodule : fifo_wrap_ptr

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with arbitrary depth, programmable
// almost-full/almost-empty thresholds, read+write acceptance when full,
// synchronous flush and a read-valid strobe.
// Build option: define FIFO_FWFT_EN for first-word-fall-through reads
// (head word shown combinationally, latency 0); otherwise reads are
// registered with latency 1.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W_DEF,
    parameter int DEPTH  = FIFO_DEPTH_DEF
) (
    input logic               clk,
    input logic               rst,
    param_sync_fifo_if.slave  bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH-1:0];
    logic [CNT_W-1:0]  r_count;
    logic              r_wr_ack;
    logic              r_overflow;
    logic              r_underflow;

    logic [ADDR_W-1:0] w_wr_ptr;
    logic [ADDR_W-1:0] w_rd_ptr;
    logic              w_rd_acc;
    logic              w_wr_acc;
    logic              w_wr_do;
    fifo_flags_t       w_flags;

    // Status is purely a function of occupancy and the live thresholds.
    assign w_flags.empty       = (r_count == '0);
    assign w_flags.full        = (r_count == FULL_CNT);
    assign w_flags.almostfull  = (r_count >= bus.af_thresh);
    assign w_flags.almostempty = (r_count <= bus.ae_thresh);

    // A full FIFO still takes a write when a read frees a slot the same cycle.
    assign w_rd_acc = bus.rd_en & ~w_flags.empty;
    assign w_wr_acc = bus.wr_en & (~w_flags.full | w_rd_acc);
    assign w_wr_do  = w_wr_acc & ~bus.clear;

    fifo_wrap_ptr #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.clear),
        .inc   (w_wr_acc),
        .ptr   (w_wr_ptr)
    );

    fifo_wrap_ptr #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clear (bus.clear),
        .inc   (w_rd_acc),
        .ptr   (w_rd_ptr)
    );

    // Storage is deliberately not reset; contents are only meaningful via count.
    always_ff @(posedge clk) begin
        if (w_wr_do) begin
            r_mem[w_wr_ptr] <= bus.data_in;
        end
    end

    // Occupancy tracks accepted writes minus accepted reads; flush zeroes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (bus.clear) begin
            r_count <= '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // One-cycle-late handshake strobes describing the previous cycle's requests.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else if (bus.clear) begin
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_wr_ack    <= w_wr_acc;
            r_overflow  <= bus.wr_en & ~w_wr_acc;
            r_underflow <= bus.rd_en & ~w_rd_acc;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is always visible; rd_en merely pops it.
    assign bus.data_out = r_mem[w_rd_ptr];
    assign bus.rd_valid = ~w_flags.empty;
`else
    logic [DATA_W-1:0] r_data_out;
    logic              r_rd_valid;

    // Registered read: data_out holds its last word until the next accepted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data_out <= '0;
            r_rd_valid <= 1'b0;
        end else if (bus.clear) begin
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_data_out <= r_mem[w_rd_ptr];
            end
        end
    end

    assign bus.data_out = r_data_out;
    assign bus.rd_valid = r_rd_valid;
`endif

    assign bus.wr_ack      = r_wr_ack;
    assign bus.overflow    = r_overflow;
    assign bus.underflow   = r_underflow;
    assign bus.count       = r_count;
    assign bus.full        = w_flags.full;
    assign bus.empty       = w_flags.empty;
    assign bus.almostfull  = w_flags.almostfull;
    assign bus.almostempty = w_flags.almostempty;

endmodule : param_sync_fifo

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo at DEPTH=5, DATA_W=16,
// af_thresh=4, ae_thresh=1 unless a sequence changes them.
module tb_param_sync_fifo;

    localparam int DW    = 16;
    localparam int DEPTH = 5;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    param_sync_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

    param_sync_fifo #(.DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic          clr;
        logic          wr;
        logic          rd;
        logic [DW-1:0] din;
        int            cnt;
        logic          full;
        logic          empty;
        logic          af;
        logic          ae;
        logic          ack;
        logic          ovf;
        logic          unf;
        logic          rdv;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void v(input logic clr, input logic wr, input logic rd,
                              input logic [DW-1:0] din, input int cnt,
                              input logic full, input logic empty,
                              input logic af, input logic ae,
                              input logic ack, input logic ovf, input logic unf,
                              input logic rdv, input logic [DW-1:0] dout);
        vec_t t;
        t.clr = clr; t.wr = wr; t.rd = rd; t.din = din; t.cnt = cnt;
        t.full = full; t.empty = empty; t.af = af; t.ae = ae;
        t.ack = ack; t.ovf = ovf; t.unf = unf; t.rdv = rdv; t.dout = dout;
        tv.push_back(t);
    endfunction

    task automatic cyc(input logic clr, input logic wr, input logic rd, input logic [DW-1:0] din);
        @(negedge clk);
        bus.clear   = clr;
        bus.wr_en   = wr;
        bus.rd_en   = rd;
        bus.data_in = din;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.clear     = 1'b0;
        bus.wr_en     = 1'b0;
        bus.rd_en     = 1'b0;
        bus.data_in   = '0;
        bus.af_thresh = CW'(4);
        bus.ae_thresh = CW'(1);

        // Fill, overflow, partial drain, wrap-around refill, full drain.
        v(0,1,0,16'hA0, 1,0,0,0,1, 1,0,0, 0,16'h0000);
        v(0,1,0,16'hA1, 2,0,0,0,0, 1,0,0, 0,16'h0000);
        v(0,1,0,16'hA2, 3,0,0,0,0, 1,0,0, 0,16'h0000);
        v(0,1,0,16'hA3, 4,0,0,1,0, 1,0,0, 0,16'h0000);
        v(0,1,0,16'hA4, 5,1,0,1,0, 1,0,0, 0,16'h0000);
        v(0,1,0,16'hA5, 5,1,0,1,0, 0,1,0, 0,16'h0000);
        v(0,0,0,16'h00, 5,1,0,1,0, 0,0,0, 0,16'h0000);
        v(0,0,1,16'h00, 4,0,0,1,0, 0,0,0, 1,16'hA0);
        v(0,0,1,16'h00, 3,0,0,0,0, 0,0,0, 1,16'hA1);
        v(0,0,1,16'h00, 2,0,0,0,0, 0,0,0, 1,16'hA2);
        v(0,1,0,16'hB0, 3,0,0,0,0, 1,0,0, 0,16'hA2);
        v(0,1,0,16'hB1, 4,0,0,1,0, 1,0,0, 0,16'hA2);
        v(0,1,0,16'hB2, 5,1,0,1,0, 1,0,0, 0,16'hA2);
        v(0,0,1,16'h00, 4,0,0,1,0, 0,0,0, 1,16'hA3);
        v(0,0,1,16'h00, 3,0,0,0,0, 0,0,0, 1,16'hA4);
        v(0,0,1,16'h00, 2,0,0,0,0, 0,0,0, 1,16'hB0);
        v(0,0,1,16'h00, 1,0,0,0,1, 0,0,0, 1,16'hB1);
        v(0,0,1,16'h00, 0,0,1,0,1, 0,0,0, 1,16'hB2);
        v(0,0,0,16'h00, 0,0,1,0,1, 0,0,0, 0,16'hB2);
        // Simultaneous write+read on empty: write only.
        v(0,1,1,16'hD5, 1,0,0,0,1, 1,0,1, 0,16'hB2);
        v(0,0,1,16'h00, 0,0,1,0,1, 0,0,0, 1,16'hD5);
        v(0,0,1,16'h00, 0,0,1,0,1, 0,0,1, 0,16'hD5);
        // Simultaneous write+read on full: both accepted, CC comes out 5th.
        v(0,1,0,16'hC0, 1,0,0,0,1, 1,0,0, 0,16'hD5);
        v(0,1,0,16'hC1, 2,0,0,0,0, 1,0,0, 0,16'hD5);
        v(0,1,0,16'hC2, 3,0,0,0,0, 1,0,0, 0,16'hD5);
        v(0,1,0,16'hC3, 4,0,0,1,0, 1,0,0, 0,16'hD5);
        v(0,1,0,16'hC4, 5,1,0,1,0, 1,0,0, 0,16'hD5);
        v(0,1,1,16'hCC, 5,1,0,1,0, 1,0,0, 1,16'hC0);
        v(0,0,1,16'h00, 4,0,0,1,0, 0,0,0, 1,16'hC1);
        v(0,0,1,16'h00, 3,0,0,0,0, 0,0,0, 1,16'hC2);
        v(0,0,1,16'h00, 2,0,0,0,0, 0,0,0, 1,16'hC3);
        v(0,0,1,16'h00, 1,0,0,0,1, 0,0,0, 1,16'hC4);
        v(0,0,1,16'h00, 0,0,1,0,1, 0,0,0, 1,16'hCC);
        // Flush with a concurrent write: nothing stored, data_out held.
        v(0,1,0,16'hE0, 1,0,0,0,1, 1,0,0, 0,16'hCC);
        v(0,1,0,16'hE1, 2,0,0,0,0, 1,0,0, 0,16'hCC);
        v(0,1,0,16'hE2, 3,0,0,0,0, 1,0,0, 0,16'hCC);
        v(1,1,0,16'hEE, 0,0,1,0,1, 0,0,0, 0,16'hCC);
        v(0,0,1,16'h00, 0,0,1,0,1, 0,0,1, 0,16'hCC);

        // Reset state while rst is held.
        repeat (2) @(posedge clk);
        #1;
        chk("rst count", 32'(bus.count), 0);
        chk("rst empty", 32'(bus.empty), 1);
        chk("rst full", 32'(bus.full), 0);
        chk("rst wr_ack", 32'(bus.wr_ack), 0);
        chk("rst rd_valid", 32'(bus.rd_valid), 0);
`ifndef FIFO_FWFT_EN
        chk("rst data_out", 32'(bus.data_out), 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        foreach (tv[i]) begin
            cyc(tv[i].clr, tv[i].wr, tv[i].rd, tv[i].din);
            chk($sformatf("v%0d count", i), 32'(bus.count), 32'(tv[i].cnt));
            chk($sformatf("v%0d full", i), 32'(bus.full), 32'(tv[i].full));
            chk($sformatf("v%0d empty", i), 32'(bus.empty), 32'(tv[i].empty));
            chk($sformatf("v%0d almostfull", i), 32'(bus.almostfull), 32'(tv[i].af));
            chk($sformatf("v%0d almostempty", i), 32'(bus.almostempty), 32'(tv[i].ae));
            chk($sformatf("v%0d wr_ack", i), 32'(bus.wr_ack), 32'(tv[i].ack));
            chk($sformatf("v%0d overflow", i), 32'(bus.overflow), 32'(tv[i].ovf));
            chk($sformatf("v%0d underflow", i), 32'(bus.underflow), 32'(tv[i].unf));
`ifndef FIFO_FWFT_EN
            chk($sformatf("v%0d rd_valid", i), 32'(bus.rd_valid), 32'(tv[i].rdv));
            chk($sformatf("v%0d data_out", i), 32'(bus.data_out), 32'(tv[i].dout));
`endif
        end

        // Threshold extremes, changed on the fly.
        bus.wr_en     = 1'b0;
        bus.rd_en     = 1'b0;
        bus.af_thresh = CW'(0);
        #1;
        chk("af_thresh=0 on empty", 32'(bus.almostfull), 1);
        bus.af_thresh = CW'(4);
        #1;
        chk("af_thresh=4 on empty", 32'(bus.almostfull), 0);
        for (int k = 0; k < DEPTH; k++) cyc(0, 1, 0, DW'(16'hF0 + k));
        chk("fill5 count", 32'(bus.count), 5);
        bus.ae_thresh = CW'(5);
        #1;
        chk("ae_thresh=5 on full", 32'(bus.almostempty), 1);
        bus.ae_thresh = CW'(7);
        #1;
        chk("ae_thresh=7 on full", 32'(bus.almostempty), 1);
        bus.ae_thresh = CW'(4);
        #1;
        chk("ae_thresh=4 on full", 32'(bus.almostempty), 0);
        bus.af_thresh = CW'(5);
        #1;
        chk("af_thresh=5 on full", 32'(bus.almostfull), 1);
        bus.af_thresh = CW'(4);
        bus.ae_thresh = CW'(1);

        // Asynchronous reset in the middle of a full-FIFO write+read burst.
        cyc(0, 1, 1, 16'h1234);
        chk("burst wr_ack", 32'(bus.wr_ack), 1);
        chk("burst count", 32'(bus.count), 5);
`ifndef FIFO_FWFT_EN
        chk("burst rd_valid", 32'(bus.rd_valid), 1);
        chk("burst data_out", 32'(bus.data_out), 32'h00F0);
`endif
        #2;
        rst = 1'b1;
        #1;
        chk("async rst count", 32'(bus.count), 0);
        chk("async rst empty", 32'(bus.empty), 1);
        chk("async rst full", 32'(bus.full), 0);
        chk("async rst wr_ack", 32'(bus.wr_ack), 0);
        chk("async rst overflow", 32'(bus.overflow), 0);
        chk("async rst underflow", 32'(bus.underflow), 0);
        chk("async rst rd_valid", 32'(bus.rd_valid), 0);
`ifndef FIFO_FWFT_EN
        chk("async rst data_out", 32'(bus.data_out), 0);
`endif
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;

`ifdef FIFO_FWFT_EN
        // Fall-through: head word visible without rd_en, pop advances it.
        cyc(0, 1, 0, 16'hA0);
        chk("fwft head after 1st write", 32'(bus.data_out), 32'h00A0);
        chk("fwft rd_valid", 32'(bus.rd_valid), 1);
        cyc(0, 1, 0, 16'hA1);
        chk("fwft head after 2nd write", 32'(bus.data_out), 32'h00A0);
        cyc(0, 0, 1, 16'h00);
        chk("fwft head after pop", 32'(bus.data_out), 32'h00A1);
        chk("fwft count after pop", 32'(bus.count), 1);
        cyc(0, 0, 1, 16'h00);
        chk("fwft rd_valid empty", 32'(bus.rd_valid), 0);
`else
        cyc(0, 1, 0, 16'h55);
        cyc(0, 0, 1, 16'h00);
        chk("post-rst read data", 32'(bus.data_out), 32'h0055);
        chk("post-rst read valid", 32'(bus.rd_valid), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_param_sync_fifo
